// File: rtl/avg_result_fifo.sv
// Result FIFO that sits behind the 12-sample sliding-window averager.
// The averager cannot be stalled. Results that arrive while the FIFO is full are
// dropped, counted in a saturating counter, and flagged with a sticky overflow bit.
// The head entry is driven combinationally from registers and is zeroed while the
// FIFO is empty. A new entry becomes visible one cycle after it is written, so
// data never falls through from in_data to out_data in the same cycle.
module avg_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int LW    = 4,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    input  logic             clr_ovf,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             ovf,
    output logic [CW-1:0]    drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    // Storage has no reset. Its contents only matter once they sit between rd_ptr and wr_ptr.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic pop;
    logic push_ok;
    logic drop;

    assign full      = (level_q == LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
    assign level     = level_q;
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_cnt_q;

    // A pop frees a slot in the same cycle, so a push into a full FIFO still succeeds when it is paired with a pop.
    assign pop     = out_valid & out_ready;
    assign push_ok = in_valid & (~full | pop);
    assign drop    = in_valid & full & ~pop;

    // Next-state logic for the pointers, the level and the drop bookkeeping.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // clr_ovf has priority. A drop in the same cycle as clr_ovf is not counted.
        if (clr_ovf) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CW'(1);
            end
        end
    end

    // Control state register with asynchronous reset. Asserting reset discards all stored entries at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Memory write port. Only accepted pushes write, so in_data is ignored when it is not being pushed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_avg_result_fifo.sv
// Self-checking bench for avg_result_fifo. A queue-based scoreboard predicts
// every pop, the level, the full flag and the drop bookkeeping.
`timescale 1ns/1ps
module tb_avg_result_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int LW    = 4;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_ready;
    logic             clr_ovf;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    level;
    logic             full;
    logic             ovf;
    logic [CW-1:0]    drop_cnt;

    int checks   = 0;
    int failures = 0;

    // Scoreboard state.
    logic [WIDTH-1:0] sb_q[$];
    int               m_ovf;
    int               m_cnt;

    avg_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LW(LW), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level),
        .full      (full),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs against the scoreboard. The bench calls this at posedge+1.
    task automatic check_state(input string tag);
        check({tag, "_level"},     32'(level),     32'(sb_q.size()));
        check({tag, "_full"},      32'(full),      32'(sb_q.size() == DEPTH));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(sb_q.size() != 0));
        check({tag, "_out_data"},  32'(out_data),  (sb_q.size() != 0) ? 32'(sb_q[0]) : 32'd0);
        check({tag, "_ovf"},       32'(ovf),       32'(m_ovf));
        check({tag, "_drop_cnt"},  32'(drop_cnt),  32'(m_cnt));
    endtask

    // Advance one clock with the current inputs, update the scoreboard, then check the outputs.
    task automatic cycle(input string tag);
        bit do_pop;
        bit dropped;
        do_pop  = (sb_q.size() != 0) && out_ready;
        dropped = 1'b0;
        if (do_pop) begin
            check({tag, "_pop"}, 32'(out_data), 32'(sb_q[0]));
            $display("pop  %s data=%h", tag, out_data);
            void'(sb_q.pop_front());
        end
        if (in_valid) begin
            if (sb_q.size() < DEPTH) begin
                sb_q.push_back(in_data);
                $display("push %s data=%h", tag, in_data);
            end else begin
                dropped = 1'b1;
                $display("drop %s data=%h", tag, in_data);
            end
        end
        if (clr_ovf) begin
            m_ovf = 0;
            m_cnt = 0;
        end else if (dropped) begin
            m_ovf = 1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = 'x;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    // Averager stand-in: returns the window sample closest to the window mean. The oldest sample wins a tie.
    function automatic logic [WIDTH-1:0] closest(input int win[$]);
        int sum = 0;
        int best;
        int bestd;
        int d;
        foreach (win[j]) sum += win[j];
        best  = win[0];
        bestd = 12 * win[0] - sum;
        if (bestd < 0) bestd = -bestd;
        foreach (win[j]) begin
            d = 12 * win[j] - sum;
            if (d < 0) d = -d;
            if (d < bestd) begin
                bestd = d;
                best  = win[j];
            end
        end
        return WIDTH'(best);
    endfunction

    initial begin
        int win[$];

        // Reset, then idle.
        idle_inputs();
        reset = 1'b1;
        m_ovf = 0;
        m_cnt = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_state("reset");
        cycle("idle_x");     // in_data is X while in_valid is low

        // Push 3, 7 and 0xFFFF, then drain them in order.
        in_valid = 1'b1;
        in_data = 16'd3;      cycle("p3");
        in_data = 16'd7;      cycle("p7");
        in_data = 16'hFFFF;   cycle("pffff");
        idle_inputs();
        out_ready = 1'b1;
        repeat (4) cycle("drain3");

        // Push 10 values into a FIFO that holds 8. The last two pushes are dropped.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_data = WIDTH'(i);
            cycle("fill10");
        end
        check("ovf_after_10", 32'(ovf), 32'd1);
        check("cnt_after_10", 32'(drop_cnt), 32'd2);
        idle_inputs();
        out_ready = 1'b1;
        repeat (9) cycle("drain10");

        // Fill the FIFO, then stream 20 values through it while it stays full.
        idle_inputs();
        clr_ovf = 1'b1;
        cycle("clr");
        clr_ovf  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = WIDTH'(200 + i);
            cycle("prefill");
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = WIDTH'(100 + i);
            cycle("stream");
        end
        check("stream_cnt", 32'(drop_cnt), 32'd0);

        // A drop in the same cycle as clr_ovf is not counted. A drop on the next cycle is.
        out_ready = 1'b0;
        clr_ovf   = 1'b1;
        in_data   = 16'hAAAA;
        cycle("drop_clr");
        check("drop_clr_ovf", 32'(ovf), 32'd0);
        clr_ovf = 1'b0;
        in_data = 16'hBBBB;
        cycle("drop_next");
        check("drop_next_cnt", 32'(drop_cnt), 32'd1);
        idle_inputs();
        out_ready = 1'b1;
        repeat (9) cycle("drain_full");

        // Assert reset mid-run with level 5. The reset is asynchronous, so the outputs clear before the next edge.
        idle_inputs();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = WIDTH'(16'h5000 + i);
            cycle("pre_rst");
        end
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        sb_q.delete();
        m_ovf = 0;
        m_cnt = 0;
        check_state("async_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        cycle("post_rst");
        idle_inputs();
        out_ready = 1'b1;
        cycle("post_rst_drain");

        // Averager hookup: samples 1..20. in_valid rises with the 12th sample, and out_ready toggles every cycle.
        idle_inputs();
        for (int s = 1; s <= 20; s++) begin
            win.push_back(s);
            if (win.size() > 12) void'(win.pop_front());
            in_valid  = (s >= 12);
            in_data   = (s >= 12) ? closest(win) : 'x;
            out_ready = s[0];
            cycle("avg");
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (10) cycle("avg_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
